// File: rtl/bcd_to_bin_converter_pkg.sv
// Shared types and constants for the packed-BCD to binary converter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OP   = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int         BCD_DIGIT_W = 4;
   localparam logic [3:0] ADJ_THRESH  = 4'd8;

   // A packed-BCD digit above 9 has no decimal meaning.
   function automatic logic digit_invalid(input logic [3:0] d);
      return (d > 4'd9);
   endfunction

endpackage

// File: rtl/bcd_to_bin_converter_if.sv
// Start/ready/done handshake and operand/result bus of the converter.
// Latency: n/a (wiring only).
// Backpressure: start is only honoured while ready=1; there is no queuing.
interface bcd_to_bin_converter_if #(
   parameter int N_DIGITS = 3,
   parameter int BIN_W    = 10
);
   logic                  start;
   logic [4*N_DIGITS-1:0] bcd_in;
   logic                  ready;
   logic                  done_tick;
   logic [BIN_W-1:0]      bin_out;
   logic                  err;

   // Controller side: issues requests, consumes results.
   modport master (
      output start, bcd_in,
      input  ready, done_tick, bin_out, err
   );

   // Converter side.
   modport slave (
      input  start, bcd_in,
      output ready, done_tick, bin_out, err
   );
endinterface

// File: rtl/bcd_to_bin_converter_digit_adjust.sv
// One-digit reverse double-dabble correction: d-3 when d>=8, else d.
// Latency: purely combinational.
// Backpressure: none.
module bcd_digit_adjust
   import bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] d,
   output logic [BCD_DIGIT_W-1:0] q
);
   // A digit that received a shifted-in 1 from the digit above carries an
   // extra 8 that should have been 5 in decimal weight, so take back 3.
   always_comb begin
      q = d;
      if (d >= ADJ_THRESH) begin
         q = d - 4'd3;
      end
   end
endmodule

// File: rtl/bcd_to_bin_converter.sv
// Iterative packed-BCD to unsigned-binary converter (reverse double-dabble).
// Latency: done_tick BIN_W cycles after the accept edge; busy for BIN_W+1 cycles.
// Backpressure: ready=0 while converting; start is ignored until ready returns.
// Optional invalid-digit check enabled by defining BCD2BIN_DIGIT_CHECK_EN.
module bcd_to_bin_converter
   import bcd_pkg::*;
#(
   parameter int N_DIGITS = 3,
   parameter int BIN_W    = 10
) (
   input  logic                    clk,
   input  logic                    reset,
   bcd_to_bin_converter_if.slave   bus
);
   localparam int BCD_W = BCD_DIGIT_W * N_DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);

   state_t             state, state_nxt;
   logic [BCD_W-1:0]   bcd_r;
   logic [BIN_W-1:0]   bin_r;
   logic [CNT_W-1:0]   n;
   logic [BIN_W-1:0]   bin_out_r;
   logic [BCD_W-1:0]   sh_bcd;
   logic [BCD_W-1:0]   adj_bcd;
   logic [BIN_W-1:0]   sh_bin;
   logic [BIN_W-1:0]   result;
   logic               accept;
   logic               last_shift;

   assign accept     = (state == IDLE) && bus.start;
   assign last_shift = (state == OP) && (n == CNT_W'(1));

   // One-bit right shift of the whole working register, zero into the top.
   always_comb begin
      {sh_bcd, sh_bin} = {bcd_r, bin_r} >> 1;
   end

   // All digits are corrected in parallel after the shift.
   for (genvar g = 0; g < N_DIGITS; g++) begin : g_adj
      bcd_digit_adjust u_adj (
         .d (sh_bcd[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .q (adj_bcd[g*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
   end

`ifdef BCD2BIN_DIGIT_CHECK_EN
   logic inv_r;
   logic err_r;
   logic bad_digit;

   // Flag any non-decimal digit in the incoming operand.
   always_comb begin
      bad_digit = 1'b0;
      for (int i = 0; i < N_DIGITS; i++) begin
         bad_digit = bad_digit | digit_invalid(bus.bcd_in[i*BCD_DIGIT_W +: BCD_DIGIT_W]);
      end
   end

   // Invalid operands still run full length; only the result is forced to 0.
   always_comb begin
      result = inv_r ? '0 : sh_bin;
   end

   // Invalid flag captured at accept, published as err at completion.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inv_r <= 1'b0;
         err_r <= 1'b0;
      end else if (accept) begin
         inv_r <= bad_digit;
      end else if (last_shift) begin
         err_r <= inv_r;
      end
   end

   assign bus.err = err_r;
`else
   // Without the check every operand is converted as-is.
   always_comb begin
      result = sh_bin;
   end

   assign bus.err = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: DONE always lasts exactly one cycle.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (bus.start) state_nxt = OP;
         OP:      if (n == CNT_W'(1)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake outputs decoded from state only.
   always_comb begin
      bus.ready     = (state == IDLE);
      bus.done_tick = (state == DONE);
   end

   // Working register, iteration counter and result register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bcd_r     <= '0;
         bin_r     <= '0;
         n         <= '0;
         bin_out_r <= '0;
      end else if (accept) begin
         bcd_r <= bus.bcd_in;
         bin_r <= '0;
         n     <= CNT_W'(BIN_W);
      end else if (state == OP) begin
         bcd_r <= adj_bcd;
         bin_r <= sh_bin;
         n     <= n - 1'b1;
         if (n == CNT_W'(1)) begin
            bin_out_r <= result;
         end
      end
   end

   assign bus.bin_out = bin_out_r;

endmodule

// File: tb/tb_bcd_to_bin_converter.sv
// Self-checking bench for bcd_to_bin_converter against a decimal-arithmetic model.
// Latency: expects done_tick 10 cycles after accept, ready back one cycle later.
// Backpressure: exercises starts issued while busy, which must be ignored.
module tb_bcd_to_bin_converter;
   localparam int N_DIGITS = 3;
   localparam int BIN_W    = 10;

   logic clk;
   logic reset;
   int   n_assert;
   int   n_fail;

   bcd_to_bin_converter_if #(.N_DIGITS(N_DIGITS), .BIN_W(BIN_W)) bus ();

   bcd_to_bin_converter #(.N_DIGITS(N_DIGITS), .BIN_W(BIN_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Decimal value of a packed BCD word.
   function automatic int ref_bin(input logic [11:0] b);
      return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
   endfunction

   function automatic bit ref_valid(input logic [11:0] b);
      return (b[11:8] <= 4'd9) && (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
   endfunction

   function automatic logic [11:0] to_bcd(input int v);
      logic [11:0] r;
      r[11:8] = 4'(v / 100);
      r[7:4]  = 4'((v / 10) % 10);
      r[3:0]  = 4'(v % 10);
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One conversion: accept, observe 14 cycles, check timing and result.
   task automatic convert(input logic [11:0] bcd, input bit inject, input string tag);
      int  first_done;
      int  n_done;
      bit  rdy_ok;
      logic [9:0] exp_bin;
      logic       exp_err;
      bit         check_bin;
      first_done = -1;
      n_done     = 0;
      rdy_ok     = 1'b1;
      check_bin  = 1'b1;
      exp_bin    = 10'(ref_bin(bcd));
      exp_err    = 1'b0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
      if (!ref_valid(bcd)) begin
         exp_bin = '0;
         exp_err = 1'b1;
      end
`else
      if (!ref_valid(bcd)) check_bin = 1'b0;
`endif
      @(negedge clk);
      check({tag, "_ready_before"}, 32'(bus.ready), 32'd1);
      bus.bcd_in = bcd;
      bus.start  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start  = 1'b0;
      bus.bcd_in = 12'h777;
      for (int k = 0; k < 14; k++) begin
         if (k > 0) @(negedge clk);
         if (bus.done_tick === 1'b1) begin
            n_done++;
            if (first_done < 0) first_done = k;
         end
         if (k <= 10 && bus.ready !== 1'b0) rdy_ok = 1'b0;
         if (k == 11 && bus.ready !== 1'b1) rdy_ok = 1'b0;
         if (inject && (k == 2 || k == 6)) begin
            bus.start  = 1'b1;
            bus.bcd_in = 12'h321;
         end else begin
            bus.start  = 1'b0;
         end
      end
      check({tag, "_done_count"}, 32'(n_done), 32'd1);
      check({tag, "_done_latency"}, 32'(first_done), 32'd10);
      check({tag, "_ready_window"}, 32'(rdy_ok), 32'd1);
      if (check_bin) check({tag, "_bin_out"}, 32'(bus.bin_out), 32'(exp_bin));
      check({tag, "_err"}, 32'(bus.err), 32'(exp_err));
   endtask

   initial begin
      int n_done;
      n_assert   = 0;
      n_fail     = 0;
      reset      = 1'b0;
      bus.start  = 1'b0;
      bus.bcd_in = '0;

      // Asynchronous reset asserted mid-cycle takes effect immediately.
      #2 reset = 1'b1;
      #1;
      check("rst_ready", 32'(bus.ready), 32'd1);
      check("rst_done", 32'(bus.done_tick), 32'd0);
      check("rst_bin_out", 32'(bus.bin_out), 32'd0);
      check("rst_err", 32'(bus.err), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Directed corner values.
      convert(12'h999, 1'b0, "c999");
      convert(12'h000, 1'b0, "c000");
      convert(12'h512, 1'b0, "c512");
      convert(12'h010, 1'b0, "c010");

      // Random valid operands.
      for (int i = 0; i < 8; i++) begin
         convert(to_bcd(int'($urandom_range(0, 999))), 1'b0, "rand");
      end

      // Starts during OP must be ignored.
      convert(12'h456, 1'b1, "ignore_start");

      // Reset in the middle of a conversion aborts it.
      @(negedge clk);
      bus.bcd_in = 12'h888;
      bus.start  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("midrst_ready", 32'(bus.ready), 32'd1);
      check("midrst_done", 32'(bus.done_tick), 32'd0);
      check("midrst_bin_out", 32'(bus.bin_out), 32'd0);
      @(negedge clk);
      reset  = 1'b0;
      n_done = 0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         if (bus.done_tick === 1'b1) n_done++;
      end
      check("midrst_no_done", 32'(n_done), 32'd0);
      check("midrst_bin_hold", 32'(bus.bin_out), 32'd0);
      convert(12'h123, 1'b0, "after_rst");

`ifdef BCD2BIN_DIGIT_CHECK_EN
      convert(12'h9A9, 1'b0, "invalid");
      convert(12'h123, 1'b0, "valid_after_invalid");
      convert({4'hF, 8'h00}, 1'b0, "invalid_top");
`endif

      // Exhaustive sweep of every valid three-digit code.
      for (int v = 0; v < 1000; v++) begin
         convert(to_bcd(v), 1'b0, "sweep");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/bcd_to_bin_converter.md
# bcd_to_bin_converter

Sequential three-digit packed-BCD to unsigned-binary converter using iterative reverse double-dabble (shift-right, then subtract 3 from each digit that is ≥8). It is the inverse path to the BCD arithmetic blocks in the chapter 3 experiments. It lets BCD values from switches or the BCD incrementor be returned to binary datapaths. A start/ready/done handshake lets a controller FSM drive it.

## Interface
- N_DIGITS, 3, number of packed BCD digits at the input
- BIN_W, 10, binary result width and iteration count; must satisfy 2^BIN_W > 10^N_DIGITS − 1
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  conversion request, sampled only while ready=1
- bcd_in  input  4*N_DIGITS  packed BCD operand, digit 0 in bits [3:0]
- ready  output  1  converter idle and able to accept start
- done_tick  output  1  one-cycle pulse when bin_out is updated
- bin_out  output  BIN_W  registered result, held until the next completion
- err  output  1  registered invalid-digit flag (see Configuration)

## Operation
- Internal working register: {bcd_r, bin_r}, width 4*N_DIGITS + BIN_W. Iteration counter n, width clog2(BIN_W+1).
- FSM states are IDLE, OP and DONE.
- IDLE:
  - ready=1.
  - On start: bcd_r ← bcd_in, bin_r ← 0, n ← BIN_W, go to OP.
- OP:
  - ready=0.
  - Each cycle, shift {bcd_r, bin_r} right by 1 (MSB ← 0). Then, for every digit of the shifted bcd_r, if digit ≥ 8, subtract 3. All digits are adjusted in parallel in the same cycle.
  - n ← n−1. When n reaches 1 on the current cycle, this is the last shift: bin_out ← shifted bin_r, then go to DONE.
- DONE:
  - ready=0, done_tick=1 for exactly one cycle.
  - Unconditionally return to IDLE.
- Start is ignored while in OP or DONE. No queuing.
- Arithmetic is unsigned. Each per-digit subtract is 4-bit and never underflows because it is applied only to values ≥8.
- Reset values:
  - State IDLE, ready=1, done_tick=0.
  - bin_out=0, err=0; internal registers 0.
- Reset mid-conversion: the conversion is aborted immediately, no done_tick is produced, and bin_out returns to 0.

## Timing
- Accept edge E0 is a rising edge with start=1 and ready=1.
- OP shifts occur on edges E1 through E_BIN_W. bin_out and err update at E_BIN_W.
- done_tick is high during the cycle between E_BIN_W and E_BIN_W+1.
- ready is low from E0 until E_BIN_W+1. Total busy time is BIN_W+1 cycles; with the defaults, done_tick is asserted 10 cycles after the accept edge.
- Back-to-back operation: with start held high, the next accept occurs at E_BIN_W+2 (the first cycle in which ready=1), giving a throughput of one conversion per BIN_W+2 cycles.
- bcd_in only needs to be valid at the accept edge.

## Configuration
- Macro BCD2BIN_DIGIT_CHECK_EN.
- Defined:
  - At the accept edge, any bcd_in digit >9 sets an internal invalid flag.
  - The conversion still runs its full length so latency is unchanged.
  - At completion, err ← 1 and bin_out ← 0. A valid operand yields err ← 0.
- Undefined:
  - The check logic is removed and err is tied to 0.
  - Digits >9 are processed by the algorithm as-is; bin_out is then unspecified but deterministic.

## Structure
- Package bcd_pkg holds:
  - The state enum typedef (IDLE, OP, DONE).
  - The localparams BCD_DIGIT_W=4 and ADJ_THRESH=8.
- Sub-module bcd_digit_adjust: purely combinational, 4 bits in and 4 bits out, outputs d−3 if d≥8 else d. It is instantiated N_DIGITS times via generate.
- The top level contains the FSM, counter, working register and output registers.

## Test plan
- Reset: assert reset asynchronously mid-cycle -> ready=1, done_tick=0, bin_out=0, err=0 immediately.
- bcd_in=12'h999, pulse start -> exactly one done_tick 10 cycles after accept, bin_out=10'd999 (0x3E7), err=0.
- Corner values: bcd_in=12'h000 -> bin_out=0. bcd_in=12'h512 -> bin_out=10'h200. bcd_in=12'h010 -> bin_out=10. Also sweep all 1000 valid codes against a reference model.
- Start pulsed at cycles 3 and 7 after accept with a different bcd_in -> both ignored, result matches the first operand, one done_tick only.
- Reset asserted at the 5th OP cycle -> no done_tick, bin_out=0, ready=1; a new start then converts normally.
- With BCD2BIN_DIGIT_CHECK_EN: bcd_in=12'h9A9 -> done_tick after 10 cycles, err=1, bin_out=0. A following 12'h123 -> err=0, bin_out=123.
